// File: rtl/cc_unit.sv
// Y86 condition-code register and jXX/cmovXX condition evaluator with registered result.
// Optional macro CC_BYPASS_EN: a coincident update/evaluate sees the incoming flags.
module cc_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow_check,
  input  logic             set_cc,
  input  logic             stall,
  input  logic             squash,
  input  logic             cond_req,
  input  logic [3:0]       ifun,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic             cnd_valid,
  output logic             bad_ifun
);

  localparam logic [2:0] CC_RST = 3'b100;

  logic [2:0] cc_q, cc_d;
  logic       cnd_q, cnd_d;
  logic       cnd_valid_q, cnd_valid_d;
  logic       bad_ifun_q, bad_ifun_d;

  logic       upd, ev, ifun_bad;
  logic [2:0] new_flags, f;
  logic       f_zf, f_sf, f_of, lt, cond;

  assign upd      = set_cc & ~stall & ~squash;
  assign ev       = cond_req & ~stall & ~squash;
  assign ifun_bad = (ifun > 4'd6);

  // {ZF, SF, OF}; the zero test spans the full result width.
  assign new_flags = {(alu_out == '0), alu_out[WIDTH-1], alu_overflow_check};

`ifdef CC_BYPASS_EN
  assign f = upd ? new_flags : cc_q;
`else
  assign f = cc_q;
`endif

  assign f_zf = f[2];
  assign f_sf = f[1];
  assign f_of = f[0];
  assign lt   = f_sf ^ f_of;

  always_comb begin
    cond = 1'b0;
    case (ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = lt | f_zf;
      4'd2:    cond = lt;
      4'd3:    cond = f_zf;
      4'd4:    cond = ~f_zf;
      4'd5:    cond = ~lt;
      4'd6:    cond = ~lt & ~f_zf;
      default: cond = 1'b0;
    endcase
  end

  // stall and squash are folded into upd/ev, so holding falls out naturally.
  always_comb begin
    cc_d        = cc_q;
    cnd_d       = cnd_q;
    cnd_valid_d = ev;
    bad_ifun_d  = bad_ifun_q;
    if (upd) cc_d = new_flags;
    if (ev) begin
      cnd_d = ifun_bad ? 1'b0 : cond;
      if (ifun_bad) bad_ifun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q        <= CC_RST;
      cnd_q       <= 1'b0;
      cnd_valid_q <= 1'b0;
      bad_ifun_q  <= 1'b0;
    end else begin
      cc_q        <= cc_d;
      cnd_q       <= cnd_d;
      cnd_valid_q <= cnd_valid_d;
      bad_ifun_q  <= bad_ifun_d;
    end
  end

  assign cc        = cc_q;
  assign cnd       = cnd_q;
  assign cnd_valid = cnd_valid_q;
  assign bad_ifun  = bad_ifun_q;

endmodule

// File: tb/tb_cc_unit.sv
// Directed self-checking bench for cc_unit: flag capture, condition sweep, stall/squash, bypass, bad ifun, reset.
module tb_cc_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_out;
  logic        alu_overflow_check;
  logic        set_cc, stall, squash, cond_req;
  logic [3:0]  ifun;
  logic [2:0]  cc;
  logic        cnd, cnd_valid, bad_ifun;

  int errors = 0;
  int checks = 0;

  cc_unit #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .alu_overflow_check(alu_overflow_check),
    .set_cc(set_cc), .stall(stall), .squash(squash), .cond_req(cond_req), .ifun(ifun),
    .cc(cc), .cnd(cnd), .cnd_valid(cnd_valid), .bad_ifun(bad_ifun)
  );

  always #5 clk = ~clk;

  task automatic idle();
    set_cc = 0; stall = 0; squash = 0; cond_req = 0; ifun = 0;
    alu_out = 0; alu_overflow_check = 0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_cc(input logic [63:0] v, input logic ov);
    idle(); set_cc = 1; alu_out = v; alu_overflow_check = ov;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    #3;
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc got=%b want=100", cc); end
    checks++; if ({cnd, cnd_valid, bad_ifun} !== 3'b000) begin errors++;
      $display("FAIL reset_outs got=%b want=000", {cnd, cnd_valid, bad_ifun}); end
    @(negedge clk); rst = 0;
    step();
  endtask

  task automatic test_flags();
    load_cc(64'h5, 1'b0);
    load_cc(64'h0, 1'b0);
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL flags_zero got=%b want=100", cc); end
    load_cc(64'h8000_0000_0000_0000, 1'b1);
    checks++; if (cc !== 3'b011) begin errors++; $display("FAIL flags_neg_ov got=%b want=011", cc); end
    load_cc(64'h5, 1'b0);
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL flags_pos got=%b want=000", cc); end
    load_cc(64'h1_0000_0000, 1'b0);
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL flags_highbit got=%b want=000", cc); end
  endtask

  task automatic sweep(input logic [6:0] exp, input string tag);
    for (int i = 0; i < 7; i++) begin
      cond_req = 1; ifun = 4'(i);
      step();
      checks++; if (cnd !== exp[i] || cnd_valid !== 1'b1) begin errors++;
        $display("FAIL sweep_%s ifun=%0d got cnd=%b vld=%b want cnd=%b vld=1", tag, i, cnd, cnd_valid, exp[i]); end
    end
    idle();
  endtask

  task automatic test_sweep();
    load_cc(64'h8000_0000_0000_0000, 1'b1);
    sweep(7'b1110001, "cc011");
    load_cc(64'h8000_0000_0000_0000, 1'b0);
    sweep(7'b0010111, "cc010");
    step();
    checks++; if (cnd_valid !== 1'b0 || cnd !== 1'b0) begin errors++;
      $display("FAIL idle_hold got cnd=%b vld=%b want cnd=0 vld=0", cnd, cnd_valid); end
  endtask

  task automatic test_stall_squash();
    logic [1:0] mode;
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m);
      idle(); set_cc = 1; alu_out = 0; cond_req = 1; ifun = 0;
      stall = mode[0]; squash = mode[1];
      step();
      checks++; if (cc !== 3'b010 || cnd_valid !== 1'b0 || cnd !== 1'b0) begin errors++;
        $display("FAIL stall_squash mode=%0d got cc=%b cnd=%b vld=%b want cc=010 cnd=0 vld=0", m, cc, cnd, cnd_valid); end
    end
    idle();
  endtask

  task automatic test_bypass();
    logic exp;
`ifdef CC_BYPASS_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    load_cc(64'h0, 1'b0);
    set_cc = 1; alu_out = 64'd7; cond_req = 1; ifun = 4'd3;
    step();
    checks++; if (cnd !== exp || cnd_valid !== 1'b1) begin errors++;
      $display("FAIL bypass got cnd=%b vld=%b want cnd=%b vld=1", cnd, cnd_valid, exp); end
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL bypass_cc got=%b want=000", cc); end
    idle();
  endtask

  task automatic test_bad_ifun();
    cond_req = 1; ifun = 0;
    step();
    cond_req = 1; ifun = 4'd9;
    step();
    checks++; if ({cnd, cnd_valid, bad_ifun} !== 3'b011) begin errors++;
      $display("FAIL bad_ifun got cnd/vld/bad=%b want=011", {cnd, cnd_valid, bad_ifun}); end
    cond_req = 1; ifun = 0;
    step();
    checks++; if ({cnd, cnd_valid, bad_ifun} !== 3'b111) begin errors++;
      $display("FAIL bad_sticky got cnd/vld/bad=%b want=111", {cnd, cnd_valid, bad_ifun}); end
    // Reset arrives mid-cycle while cnd_valid is high.
    #2 rst = 1; #1;
    checks++; if ({cc, cnd, cnd_valid, bad_ifun} !== 6'b100000) begin errors++;
      $display("FAIL reset_mid got cc/cnd/vld/bad=%b want=100000", {cc, cnd, cnd_valid, bad_ifun}); end
    idle();
    @(negedge clk); rst = 0;
    step();
    cond_req = 1; ifun = 4'd7;
    step();
    checks++; if ({cnd, cnd_valid, bad_ifun} !== 3'b011) begin errors++;
      $display("FAIL bad_ifun7 got cnd/vld/bad=%b want=011", {cnd, cnd_valid, bad_ifun}); end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_flags();
    test_sweep();
    test_stall_squash();
    test_bypass();
    test_bad_ifun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
